clk_gate_ctrl: RTL

Clock-gate sequencer that drives the CE pin of a global clock buffer (BUFGCE, CE_TYPE "SYNC") feeding a gated clock region. It arbitrates among N_REQ requesters that need the gated clock, applies a settle delay before granting, holds the clock on for a hysteresis window after the last request drops, and enforces a minimum off time before re-enabling. The block runs on the free-running clock that also feeds the buffer's I input and sits beside the buffer instance at the clock-tree top level.

---
 rtl/clk_gate_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-gate sequencer that drives the CE pin of a synchronous-CE global clock buffer.
// It arbitrates requesters, waits a settle delay before granting, and holds the clock on through a hysteresis window.
module clk_gate_ctrl #(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             force_on,
  input  logic             cnt_clr,
  output logic             ce_o,
  output logic             running,
  output logic [N_REQ-1:0] ack,
  output logic [2:0]       state_o,
  output logic [15:0]      on_cycles
);

  // An out-of-range parameter stops elaboration, so a bad configuration cannot be built.
  if (N_REQ == 0 || N_REQ > 8 ||
      SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255 ||
      HOLD_CYCLES == 0 || HOLD_CYCLES > 255) begin : g_param_err
    $fatal(1, "Attribute Syntax Error: clk_gate_ctrl N_REQ=%0d SETTLE_CYCLES=%0d HOLD_CYCLES=%0d",
           N_REQ, SETTLE_CYCLES, HOLD_CYCLES);
  end

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_WAKE  = 3'd1;
  localparam logic [2:0] S_ON    = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        ce_q,    ce_d;
  logic        run_q,   run_d;
  logic [15:0] on_q,    on_d;
  logic        any_req;

  assign any_req = (|req) | force_on;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_d    = ce_q;
    run_d   = run_q;
    case (state_q)
      S_OFF: begin
        if (any_req) begin
          state_d = S_WAKE;
          ce_d    = 1'b1;
          cnt_d   = SETTLE_LD;
        end
      end
      // Dropping the request here does not abort; ON decides afterwards.
      S_WAKE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_ON;
          run_d   = 1'b1;
        end
      end
      S_ON: begin
        if (!any_req) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      // A request on the expiry edge wins over the timeout.
      S_HOLD: begin
        if (any_req) begin
          state_d = S_ON;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_DRAIN;
          ce_d    = 1'b0;
          run_d   = 1'b0;
          cnt_d   = SETTLE_LD;
        end
      end
      // Requests are ignored until the buffer has settled off.
      S_DRAIN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        ce_d    = 1'b0;
        run_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    on_d = on_q;
    if (cnt_clr) begin
      on_d = '0;
    end else if (ce_q && (on_q != '1)) begin
      on_d = on_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      run_q   <= 1'b0;
      on_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      run_q   <= run_d;
      on_q    <= on_d;
    end
  end

  assign ce_o      = ce_q;
  assign running   = run_q;
  assign state_o   = state_q;
  assign on_cycles = on_q;
  assign ack       = req & {N_REQ{run_q}};

endmodule
